// File: rtl/cu_pkg.sv
// Shared definitions for the control sequencer: state encoding, opcodes, ALU select map.
// CU_MULDIV_EN adds mul/div as a four-step execute class; without it they decode as nop.
package cu_pkg;

  // T0..T6 must stay consecutive: the sequencer steps through them by increment.
  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_HALT  = 4'd8
  } state_t;

  typedef enum logic [2:0] {
    CL_NOP,
    CL_R3,
    CL_R2,
    CL_MD,
    CL_HALT
  } op_class_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_NOP  = 5'b11000;
  localparam logic [4:0] OP_HALT = 5'b11001;

  localparam int ALU_W   = 12;
  localparam int ALU_ADD = 0;
  localparam int ALU_SUB = 1;
  localparam int ALU_SHR = 2;
  localparam int ALU_SHL = 3;
  localparam int ALU_ROR = 4;
  localparam int ALU_ROL = 5;
  localparam int ALU_AND = 6;
  localparam int ALU_OR  = 7;
  localparam int ALU_MUL = 8;
  localparam int ALU_NEG = 9;
  localparam int ALU_DIV = 10;
  localparam int ALU_NOT = 11;

  function automatic op_class_t op_class(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR:  op_class = CL_R3;
      OP_NEG, OP_NOT:                 op_class = CL_R2;
`ifdef CU_MULDIV_EN
      OP_MUL, OP_DIV:                 op_class = CL_MD;
`endif
      OP_HALT:                        op_class = CL_HALT;
      default:                        op_class = CL_NOP;
    endcase
  endfunction

  function automatic logic [ALU_W-1:0] alu_sel(input logic [4:0] op);
    logic [ALU_W-1:0] one;
    one = ALU_W'(1);
    case (op)
      OP_ADD:  alu_sel = one << ALU_ADD;
      OP_SUB:  alu_sel = one << ALU_SUB;
      OP_SHR:  alu_sel = one << ALU_SHR;
      OP_SHL:  alu_sel = one << ALU_SHL;
      OP_ROR:  alu_sel = one << ALU_ROR;
      OP_ROL:  alu_sel = one << ALU_ROL;
      OP_AND:  alu_sel = one << ALU_AND;
      OP_OR:   alu_sel = one << ALU_OR;
`ifdef CU_MULDIV_EN
      OP_MUL:  alu_sel = one << ALU_MUL;
      OP_DIV:  alu_sel = one << ALU_DIV;
`endif
      OP_NEG:  alu_sel = one << ALU_NEG;
      OP_NOT:  alu_sel = one << ALU_NOT;
      default: alu_sel = '0;
    endcase
  endfunction

  // Final execute step for each class; stop is sampled here.
  function automatic state_t last_step(input op_class_t c);
    case (c)
      CL_R3:   last_step = S_T5;
      CL_R2:   last_step = S_T4;
      CL_MD:   last_step = S_T6;
      default: last_step = S_T3;
    endcase
  endfunction

endpackage

// File: rtl/cu_reg_decode.sv
// Register index to one-hot enable decoder; all-zero when not enabled.
module cu_reg_decode #(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4
) (
  input  logic [IDX_W-1:0]    idx,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot
);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_bit
    assign onehot[i] = en && (idx == IDX_W'(i));
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: three fetch steps then a per-opcode execute sequence.
// Define CU_MULDIV_EN to enable the mul/div execute sequence (T3..T6).
module control_sequencer
  import cu_pkg::*;
(
  input  logic             clock,
  input  logic             clr,
  input  logic [31:0]      IR,
  input  logic             stop,
  output logic [15:0]      Rout,
  output logic [15:0]      Rin,
  output logic             HIout,
  output logic             LOout,
  output logic             Zhighout,
  output logic             Zlowout,
  output logic             PCout,
  output logic             MDRout,
  output logic             Cout,
  output logic             PCin,
  output logic             Yin,
  output logic             Zlow_in,
  output logic             Zhigh_in,
  output logic             MARin,
  output logic             HIin,
  output logic             LOin,
  output logic             IRin,
  output logic             MDRin,
  output logic             MDRread,
  output logic             incPC,
  output logic [ALU_W-1:0] ALUin,
  output logic             run
);

  state_t           state;
  op_class_t        cls;
  logic [3:0]       ra, rb, rc;
  logic [3:0]       rout_idx, rin_idx;
  logic             rout_en, rin_en;
  logic [ALU_W-1:0] alu_op;
  logic             unused_ir;

  assign cls       = op_class(IR[31:27]);
  assign alu_op    = alu_sel(IR[31:27]);
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign unused_ir = ^IR[14:0];

  always_ff @(posedge clock or negedge clr) begin
    if (!clr) begin
      state <= S_RESET;
    end else begin
      case (state)
        S_RESET: state <= S_T0;
        S_T0:    state <= S_T1;
        S_T1:    state <= S_T2;
        S_T2:    state <= S_T3;
        S_T3, S_T4, S_T5, S_T6: begin
          if (cls == CL_HALT)
            state <= S_HALT;
          else if (state >= last_step(cls))
            state <= stop ? S_HALT : S_T0;
          else
            state <= state_t'(state + 4'd1);
        end
        default: state <= S_HALT;
      endcase
    end
  end

  always_comb begin
    rout_idx = '0;
    rout_en  = 1'b0;
    rin_idx  = '0;
    rin_en   = 1'b0;
    HIout    = 1'b0;
    LOout    = 1'b0;
    Zhighout = 1'b0;
    Zlowout  = 1'b0;
    PCout    = 1'b0;
    MDRout   = 1'b0;
    Cout     = 1'b0;
    PCin     = 1'b0;
    Yin      = 1'b0;
    Zlow_in  = 1'b0;
    Zhigh_in = 1'b0;
    MARin    = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    IRin     = 1'b0;
    MDRin    = 1'b0;
    MDRread  = 1'b0;
    incPC    = 1'b0;
    ALUin    = '0;
    run      = (state != S_RESET) && (state != S_HALT);
    case (state)
      S_T0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        incPC   = 1'b1;
        Zlow_in = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        MDRread = 1'b1;
        MDRin   = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        case (cls)
          CL_R3: begin
            rout_idx = rb;
            rout_en  = 1'b1;
            Yin      = 1'b1;
          end
          CL_R2: begin
            rout_idx = rb;
            rout_en  = 1'b1;
            ALUin    = alu_op;
            Zlow_in  = 1'b1;
            Zhigh_in = 1'b1;
          end
          CL_MD: begin
            rout_idx = ra;
            rout_en  = 1'b1;
            Yin      = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        case (cls)
          CL_R3: begin
            rout_idx = rc;
            rout_en  = 1'b1;
            ALUin    = alu_op;
            Zlow_in  = 1'b1;
            Zhigh_in = 1'b1;
          end
          CL_R2: begin
            Zlowout = 1'b1;
            rin_idx = ra;
            rin_en  = 1'b1;
          end
          CL_MD: begin
            rout_idx = rb;
            rout_en  = 1'b1;
            ALUin    = alu_op;
            Zlow_in  = 1'b1;
            Zhigh_in = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        case (cls)
          CL_R3: begin
            Zlowout = 1'b1;
            rin_idx = ra;
            rin_en  = 1'b1;
          end
          CL_MD: begin
            Zlowout = 1'b1;
            LOin    = 1'b1;
          end
          default: ;
        endcase
      end
      S_T6: begin
        if (cls == CL_MD) begin
          Zhighout = 1'b1;
          HIin     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // One decoder per bus direction keeps Rout and Rin one-hot by construction.
  cu_reg_decode u_rout_dec (
    .idx    (rout_idx),
    .en     (rout_en),
    .onehot (Rout)
  );

  cu_reg_decode u_rin_dec (
    .idx    (rin_idx),
    .en     (rin_en),
    .onehot (Rin)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer: per-instruction step lists built from the ISA tables.
`timescale 1ns/1ps
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clr   = 1'b1;
  logic        stop  = 1'b0;
  logic [31:0] IR    = '0;
  logic [15:0] Rout, Rin;
  logic        HIout, LOout, Zhighout, Zlowout, PCout, MDRout, Cout;
  logic        PCin, Yin, Zlow_in, Zhigh_in, MARin, HIin, LOin, IRin, MDRin, MDRread, incPC;
  logic [11:0] ALUin;
  logic        run;

  control_sequencer dut (
    .clock(clock), .clr(clr), .IR(IR), .stop(stop),
    .Rout(Rout), .Rin(Rin),
    .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .PCout(PCout), .MDRout(MDRout), .Cout(Cout),
    .PCin(PCin), .Yin(Yin), .Zlow_in(Zlow_in), .Zhigh_in(Zhigh_in), .MARin(MARin),
    .HIin(HIin), .LOin(LOin), .IRin(IRin), .MDRin(MDRin), .MDRread(MDRread), .incPC(incPC),
    .ALUin(ALUin), .run(run)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        run;
    logic [15:0] Rout;
    logic [15:0] Rin;
    logic HIout, LOout, Zhighout, Zlowout, PCout, MDRout, Cout;
    logic PCin, Yin, Zlow_in, Zhigh_in, MARin, HIin, LOin, IRin, MDRin, MDRread, incPC;
    logic [11:0] ALUin;
  } out_t;

  out_t act, exp_out;
  bit   exp_valid = 0;
  int   checks = 0, errors = 0;
  out_t seq[$];

  always_comb begin
    act = '0;
    act.run = run; act.Rout = Rout; act.Rin = Rin;
    act.HIout = HIout; act.LOout = LOout; act.Zhighout = Zhighout; act.Zlowout = Zlowout;
    act.PCout = PCout; act.MDRout = MDRout; act.Cout = Cout;
    act.PCin = PCin; act.Yin = Yin; act.Zlow_in = Zlow_in; act.Zhigh_in = Zhigh_in;
    act.MARin = MARin; act.HIin = HIin; act.LOin = LOin; act.IRin = IRin;
    act.MDRin = MDRin; act.MDRread = MDRread; act.incPC = incPC; act.ALUin = ALUin;
  end

  // Single cycle-by-cycle comparison against the model's expected outputs.
  always @(negedge clock) begin
    if (exp_valid) begin
      checks++;
      if (act !== exp_out) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t got=%h exp=%h", $time, act, exp_out);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, want);
    end
  endtask

  // Instruction classes: 0 nop/undefined, 1 three-register, 2 two-register, 3 mul/div, 4 halt.
  function automatic int kind(input logic [4:0] op);
    if (op >= 5'd3 && op <= 5'd10) return 1;
    if (op == 5'd16 || op == 5'd17) return 2;
`ifdef CU_MULDIV_EN
    if (op == 5'd14 || op == 5'd15) return 3;
`endif
    if (op == 5'd25) return 4;
    return 0;
  endfunction

  function automatic logic [11:0] alu_of(input logic [4:0] op);
    int b;
    logic [11:0] one;
    one = 12'd1;
    case (op)
      5'd3: b = 0;   5'd4: b = 1;   5'd5: b = 2;   5'd6: b = 3;
      5'd7: b = 4;   5'd8: b = 5;   5'd9: b = 6;   5'd10: b = 7;
      5'd14: b = 8;  5'd16: b = 9;  5'd15: b = 10; 5'd17: b = 11;
      default: b = -1;
    endcase
    return (b < 0) ? 12'd0 : (one << b);
  endfunction

  function automatic logic [15:0] oh(input logic [3:0] i);
    logic [15:0] one;
    one = 16'd1;
    return one << i;
  endfunction

  task automatic build(input logic [31:0] ir);
    out_t s;
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    op = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
    seq.delete();
    s = '0; s.run = 1; s.PCout = 1; s.MARin = 1; s.incPC = 1; s.Zlow_in = 1; seq.push_back(s);
    s = '0; s.run = 1; s.Zlowout = 1; s.PCin = 1; s.MDRread = 1; s.MDRin = 1; seq.push_back(s);
    s = '0; s.run = 1; s.MDRout = 1; s.IRin = 1; seq.push_back(s);
    case (kind(op))
      1: begin
        s = '0; s.run = 1; s.Rout = oh(rb); s.Yin = 1; seq.push_back(s);
        s = '0; s.run = 1; s.Rout = oh(rc); s.ALUin = alu_of(op); s.Zlow_in = 1; s.Zhigh_in = 1; seq.push_back(s);
        s = '0; s.run = 1; s.Zlowout = 1; s.Rin = oh(ra); seq.push_back(s);
      end
      2: begin
        s = '0; s.run = 1; s.Rout = oh(rb); s.ALUin = alu_of(op); s.Zlow_in = 1; s.Zhigh_in = 1; seq.push_back(s);
        s = '0; s.run = 1; s.Zlowout = 1; s.Rin = oh(ra); seq.push_back(s);
      end
      3: begin
        s = '0; s.run = 1; s.Rout = oh(ra); s.Yin = 1; seq.push_back(s);
        s = '0; s.run = 1; s.Rout = oh(rb); s.ALUin = alu_of(op); s.Zlow_in = 1; s.Zhigh_in = 1; seq.push_back(s);
        s = '0; s.run = 1; s.Zlowout = 1; s.LOin = 1; seq.push_back(s);
        s = '0; s.run = 1; s.Zhighout = 1; s.HIin = 1; seq.push_back(s);
      end
      default: begin
        s = '0; s.run = 1; seq.push_back(s);
      end
    endcase
  endtask

  // Caller sits just before the clock edge that enters T0.
  task automatic run_instr(input logic [31:0] ir, input bit s_last, input bit chk_t0, output bit halted);
    build(ir);
    for (int k = 0; k < seq.size(); k++) begin
      @(posedge clock); #1;
      if (k == 0) IR = ir;
      exp_out = seq[k];
      stop = (k == seq.size() - 1) ? s_last : 1'($urandom);
      if (k == 0 && chk_t0)
        check("t0_after_release", {59'd0, PCout, MARin, incPC, Zlow_in, run}, 64'h1f);
    end
    halted = s_last || (ir[31:27] == 5'b11001);
  endtask

  task automatic halt_idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
      exp_out = '0; stop = 1'($urandom); IR = $urandom;
    end
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    clr = 1'b0; exp_out = '0;
    #1 check("clr_forces_zero", 64'(act), 64'd0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    clr = 1'b1;
  endtask

  initial begin
    bit h;
    logic [31:0] ir;

    // Model pins against hand-derived values.
    build(32'h4A920000);
    check("pin_and_len", 64'(seq.size()), 64'd6);
    check("pin_and_t3_rout", 64'(seq[3].Rout), 64'h0004);
    check("pin_and_t4_rout", 64'(seq[4].Rout), 64'h0010);
    check("pin_and_t4_alu", 64'(seq[4].ALUin), 64'h040);
    check("pin_and_t5_rin", 64'(seq[5].Rin), 64'h0020);
    build(32'h82900000);
    check("pin_neg_len", 64'(seq.size()), 64'd5);
    check("pin_neg_t3_alu", 64'(seq[3].ALUin), 64'h200);
    check("pin_neg_t4_rin", 64'(seq[4].Rin), 64'h0020);
    build(32'h71100000);
`ifdef CU_MULDIV_EN
    check("pin_mul_len", 64'(seq.size()), 64'd7);
    check("pin_mul_hilo", {62'd0, seq[5].LOin, seq[6].HIin}, 64'd3);
`else
    check("pin_mul_len", 64'(seq.size()), 64'd4);
`endif

    exp_out = '0;
    #1 clr = 1'b0;
    #1 exp_valid = 1;
    check("reset_run_low", 64'(run), 64'd0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    clr = 1'b1;

    run_instr(32'h4A920000, 1'b0, 1'b1, h);
    run_instr(32'h82900000, 1'b0, 1'b0, h);
    run_instr(32'h71100000, 1'b0, 1'b0, h);
    run_instr(32'hC0000000, 1'b0, 1'b0, h);

    // stop on the last step of an add halts and holds.
    run_instr(32'h1A920000, 1'b1, 1'b0, h);
    halt_idle(5);
    do_reset();
    run_instr(32'h2A920000, 1'b0, 1'b1, h);

    // clr during T4 of an add.
    build(32'h1A920000);
    for (int k = 0; k <= 4; k++) begin
      @(posedge clock); #1;
      if (k == 0) IR = 32'h1A920000;
      exp_out = seq[k];
      stop = 1'($urandom);
    end
    @(negedge clock); #1;
    clr = 1'b0; exp_out = '0;
    #1 check("clr_mid_t4", 64'(act), 64'd0);
    @(posedge clock); #1;
    clr = 1'b1;
    run_instr(32'h4A920000, 1'b0, 1'b1, h);

    // halt opcode ignores stop and parks.
    run_instr(32'hC8000000, 1'b0, 1'b0, h);
    halt_idle(3);
    do_reset();

    for (int n = 0; n < 150; n++) begin
      ir = $urandom;
      if (ir[31:27] == 5'b11001 && $urandom_range(0, 2) != 0) ir[31:27] = 5'b00011;
      run_instr(ir, ($urandom_range(0, 9) == 0), 1'b0, h);
      if (h) begin
        halt_idle($urandom_range(1, 4));
        do_reset();
      end
    end

    @(posedge clock); #1;
    exp_valid = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port clock, input, 1, single system clock; all state changes on its rising edge.
REQ-002 SHALL have port clr, input, 1, asynchronous, active-low reset.
REQ-003 SHALL have port IR, input, 32, instruction register contents; opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15].
REQ-004 SHALL have port stop, input, 1, halt request, sampled on the last step of each instruction.
REQ-005 SHALL have port Rout, output, 16, one-hot register-to-bus enables for R0..R15.
REQ-006 SHALL have port Rin, output, 16, one-hot bus-to-register load enables for R0..R15.
REQ-007 SHALL have 1-bit outputs HIout, LOout, Zhighout, Zlowout, PCout, MDRout, Cout, each a bus-drive enable.
REQ-008 SHALL have 1-bit outputs PCin, Yin, Zlow_in, Zhigh_in, MARin, HIin, LOin, IRin, MDRin, MDRread, incPC, each a load or strobe enable.
REQ-009 SHALL have port ALUin, output, 12, one-hot ALU operation select.
REQ-010 SHALL have port run, output, 1, high while sequencing and low in RESET and HALT.

Function
REQ-011 SHALL implement states RESET, T0, T1, T2, T3, T4, T5, T6 and HALT.
REQ-012 SHALL drive all outputs combinationally from the present state and IR, with every output 0 except where this section asserts it.
REQ-013 SHALL perform fetch as follows: T0 PCout, MARin, incPC, Zlow_in; T1 Zlowout, PCin, MDRread, MDRin; T2 MDRout, IRin.
REQ-014 SHALL decode in T3 onward from IR, which holds the word loaded at the end of T2.
REQ-015 SHALL execute 3-register ops (add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010) as: T3 Rout[Rb], Yin; T4 Rout[Rc], ALUin=op, Zlow_in, Zhigh_in; T5 Zlowout, Rin[Ra].
REQ-016 SHALL execute neg 10000 and not 10001 as: T3 Rout[Rb], ALUin=op, Zlow_in, Zhigh_in; T4 Zlowout, Rin[Ra].
REQ-017 SHALL execute mul 01110 and div 01111 as: T3 Rout[Ra], Yin; T4 Rout[Rb], ALUin=op, Zlow_in, Zhigh_in; T5 Zlowout, LOin; T6 Zhighout, HIin.
REQ-018 SHALL treat nop 11000 and every undefined opcode as T3 with no outputs asserted, then return to T0.
REQ-019 SHALL execute halt 11001 as T3 → HALT.
REQ-020 SHALL go from the last execute step to T0 when stop=0, and to HALT when stop=1.
REQ-021 SHALL use ALUin one-hot bits: 0 add, 1 sub, 2 shr, 3 shl, 4 ror, 5 rol, 6 and, 7 or, 8 mul, 9 neg, 10 div, 11 not.
REQ-022 SHALL keep each of Rout and Rin at most one-hot in every state.
REQ-023 SHALL leave HALT only through clr; in HALT all outputs are 0 and run=0.

Reset
REQ-024 SHALL force state RESET and all outputs 0 immediately when clr=0, including mid-instruction.
REQ-025 SHALL enter T0 with run=1 on the first rising clock edge after clr deasserts.

Configuration
REQ-026 SHALL, with CU_MULDIV_EN defined, implement the mul/div sequence of REQ-017.
REQ-027 SHALL, without CU_MULDIV_EN, treat opcodes 01110 and 01111 as nop, never assert ALUin bits 8 or 10, and never enter T6.

Structure
REQ-028 SHALL take opcode constants, the ALUin bit map and the state encoding from shared package cu_pkg.
REQ-029 SHALL instantiate sub-module cu_reg_decode (4-bit index + enable → 16-bit one-hot) for both Rout and Rin.

Verification
REQ-030 SHALL cover: clr low, release → after one clock, state T0 with PCout=MARin=incPC=Zlow_in=1 and run=1.
REQ-031 SHALL cover: IR=0x4A920000 (and R5,R2,R4) → T3 Rout=16'h0004 with Yin; T4 Rout=16'h0010 with ALUin=12'h040; T5 Zlowout with Rin=16'h0020.
REQ-032 SHALL cover: IR=0x82900000 (neg R5,R2) → T3 Rout=16'h0004 with ALUin=12'h200; T4 Rin=16'h0020; next state T0.
REQ-033 SHALL cover: IR=0x71100000 (mul R2,R2) → T5 LOin, T6 HIin when CU_MULDIV_EN is defined; nop behaviour when it is not.
REQ-034 SHALL cover: stop=1 during T5 of an add → HALT with all outputs 0, held until clr.
REQ-035 SHALL cover: clr asserted during T4 → outputs 0 in the same cycle; restart at T0 after release.
